// File: rtl/ascii_scroll_ctrl.sv
// Scroll controller for a five-digit ASCII display: writable message buffer with a
// five-character window that optionally scrolls left once every TickDiv cycles.
module ascii_scroll_ctrl #(
  parameter int unsigned Depth   = 16,
  parameter int unsigned TickDiv = 12_500_000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(Depth)-1:0] wr_addr_i,
  input  logic [7:0]               wr_data_i,
  input  logic [$clog2(Depth):0]   msg_len_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     pause_i,
  output logic [7:0]               char4_o,
  output logic [7:0]               char3_o,
  output logic [7:0]               char2_o,
  output logic [7:0]               char1_o,
  output logic [7:0]               char0_o,
  output logic                     scrolling_o,
  output logic                     wrap_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = (TickDiv > 1) ? $clog2(TickDiv) : 1;

  typedef enum logic [1:0] {StIdle, StScroll, StPause} state_e;

  state_e         st_q, st_d;
  logic [AW-1:0]  off_q, off_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [LW-1:0]  len_q, len_d;
  logic           wrap_evt_q, wrap_evt_d;
  logic [7:0]     mem_q [Depth];
  logic [7:0]     char_q [5];
  logic           scrolling_q;
  logic           wrap_q;

  logic [LW-1:0]  len_clamp;
  logic [LW-1:0]  off_inc;
  logic [AW-1:0]  idx [5];

  // Modulo-L increment by compare-and-subtract; a is always below l.
  function automatic logic [AW-1:0] inc_mod(input logic [AW-1:0] a, input logic [LW-1:0] l);
    logic [LW-1:0] n;
    n = {1'b0, a} + LW'(1);
    return (n == l) ? '0 : n[AW-1:0];
  endfunction

  always_comb begin
    len_clamp = msg_len_i;
    if (msg_len_i == '0) begin
      len_clamp = LW'(1);
    end else if (msg_len_i > LW'(Depth)) begin
      len_clamp = LW'(Depth);
    end
  end

  assign off_inc = {1'b0, off_q} + LW'(1);

  always_comb begin
    st_d       = st_q;
    off_d      = off_q;
    tick_d     = tick_q;
    wrap_evt_d = 1'b0;
    // L follows MsgLen while idle and is frozen from Start onwards.
    len_d      = (st_q == StIdle || start_i) ? len_clamp : len_q;
    unique case (st_q)
      StIdle: begin
        off_d  = '0;
        tick_d = '0;
        if (start_i && !stop_i) st_d = StScroll;
      end
      StScroll, StPause: begin
        if (stop_i) begin
          st_d   = StIdle;
          off_d  = '0;
          tick_d = '0;
        end else if (start_i) begin
          st_d   = StScroll;
          off_d  = '0;
          tick_d = '0;
        end else if (pause_i) begin
          st_d = StPause;
        end else begin
          // Leaving PAUSE counts this cycle, so a deferred tick fires right away.
          st_d = StScroll;
          if (tick_q == TW'(TickDiv - 1)) begin
            tick_d = '0;
            if (off_inc == len_q) begin
              off_d      = '0;
              wrap_evt_d = 1'b1;
            end else begin
              off_d = off_inc[AW-1:0];
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_comb begin
    idx[0] = off_q;
    for (int i = 1; i < 5; i++) begin
      idx[i] = inc_mod(idx[i-1], len_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q        <= StIdle;
      off_q       <= '0;
      tick_q      <= '0;
      len_q       <= LW'(1);
      wrap_evt_q  <= 1'b0;
      scrolling_q <= 1'b0;
      wrap_q      <= 1'b0;
      for (int i = 0; i < 5; i++) char_q[i] <= 8'h20;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= 8'h20;
    end else begin
      st_q        <= st_d;
      off_q       <= off_d;
      tick_q      <= tick_d;
      len_q       <= len_d;
      wrap_evt_q  <= wrap_evt_d;
      scrolling_q <= (st_q != StIdle);
      wrap_q      <= wrap_evt_q;
      for (int i = 0; i < 5; i++) char_q[4-i] <= mem_q[idx[i]];
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign char4_o     = char_q[4];
  assign char3_o     = char_q[3];
  assign char2_o     = char_q[2];
  assign char1_o     = char_q[1];
  assign char0_o     = char_q[0];
  assign scrolling_o = scrolling_q;
  assign wrap_o      = wrap_q;

endmodule
